// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared source ids, tag constants and helpers for the CDB arbiter
package cdb_arbiter_pkg;

  localparam int TAG_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int NO_ENTRY   = 0;

  typedef enum logic [1:0] {
    CDB_SRC_RS     = 2'd0,
    CDB_SRC_BRANCH = 2'd1,
    CDB_SRC_SLB    = 2'd2,
    CDB_SRC_NONE   = 2'd3
  } cdb_src_e;

  // Round-robin successor over the three real sources (2 wraps to 0).
  function automatic logic [1:0] src_next(input logic [1:0] s);
    return (s >= 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_slot.sv
// rtl/cdb_slot.sv - one-entry result holding register with load, grant and flush
module cdb_slot #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clear,
  input  logic         load,
  input  logic         grant,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Load wins over grant so a slot drained this cycle can be refilled at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (rdy) begin
      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (grant) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbitration of three producer slots onto a registered CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              have_rs,
  input  logic              have_branch,
  input  logic              have_slb,
  input  logic [TAG_W-1:0]  entry_rs,
  input  logic [TAG_W-1:0]  entry_branch,
  input  logic [TAG_W-1:0]  entry_slb,
  input  logic [DATA_W-1:0] value_rs,
  input  logic [DATA_W-1:0] value_branch,
  input  logic [DATA_W-1:0] value_slb,
  input  logic              pc_change_branch,
  input  logic [31:0]       new_pc_branch,
  output logic              stall_rs,
  output logic              stall_branch,
  output logic              stall_slb,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_entry,
  output logic [DATA_W-1:0] cdb_value,
  output logic [1:0]        cdb_src,
  output logic              cdb_pc_change,
  output logic [31:0]       cdb_new_pc
);

  localparam int BASE_W = TAG_W + DATA_W;
  localparam int BR_W   = BASE_W + 33;

  logic [2:0]        have, entry_ok, slot_valid, grant, stall, load;
  logic [BASE_W-1:0] rs_data, slb_data;
  logic [BR_W-1:0]   br_data;
  logic [1:0]        rr_ptr;
  logic [1:0]        idx;
  cdb_src_e          gidx;

  assign have     = {have_slb, have_branch, have_rs};
  assign entry_ok = {entry_slb    != TAG_W'(NO_ENTRY),
                     entry_branch != TAG_W'(NO_ENTRY),
                     entry_rs     != TAG_W'(NO_ENTRY)};
  assign stall    = {3{!rdy_in}} | (slot_valid & ~grant);
  assign load     = have & ~stall & entry_ok & {3{rdy_in & !clear_in}};

  assign stall_rs     = stall[0];
  assign stall_branch = stall[1];
  assign stall_slb    = stall[2];

  always_comb begin
    grant = '0;
    gidx  = CDB_SRC_NONE;
    idx   = rr_ptr;
    for (int i = 0; i < 3; i++) begin
      if (gidx == CDB_SRC_NONE && slot_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = cdb_src_e'(idx);
      end
      idx = src_next(idx);
    end
  end

  cdb_slot #(.W(BASE_W)) u_slot_rs (
    .clk(clk_in), .rst(rst_in), .rdy(rdy_in), .clear(clear_in),
    .load(load[0]), .grant(grant[0]), .load_data({entry_rs, value_rs}),
    .valid(slot_valid[0]), .data(rs_data)
  );

  cdb_slot #(.W(BR_W)) u_slot_branch (
    .clk(clk_in), .rst(rst_in), .rdy(rdy_in), .clear(clear_in),
    .load(load[1]), .grant(grant[1]),
    .load_data({pc_change_branch, new_pc_branch, entry_branch, value_branch}),
    .valid(slot_valid[1]), .data(br_data)
  );

  cdb_slot #(.W(BASE_W)) u_slot_slb (
    .clk(clk_in), .rst(rst_in), .rdy(rdy_in), .clear(clear_in),
    .load(load[2]), .grant(grant[2]), .load_data({entry_slb, value_slb}),
    .valid(slot_valid[2]), .data(slb_data)
  );

  // Without a grant only valid/src change; payload fields keep the last broadcast.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr        <= 2'd0;
      cdb_valid     <= 1'b0;
      cdb_entry     <= '0;
      cdb_value     <= '0;
      cdb_src       <= CDB_SRC_NONE;
      cdb_pc_change <= 1'b0;
      cdb_new_pc    <= '0;
    end else if (rdy_in) begin
      if (clear_in || gidx == CDB_SRC_NONE) begin
        cdb_valid <= 1'b0;
        cdb_src   <= CDB_SRC_NONE;
        if (clear_in) rr_ptr <= 2'd0;
      end else begin
        cdb_valid <= 1'b1;
        cdb_src   <= gidx;
        rr_ptr    <= src_next(gidx);
        case (gidx)
          CDB_SRC_RS: begin
            cdb_entry     <= rs_data[BASE_W-1:DATA_W];
            cdb_value     <= rs_data[DATA_W-1:0];
            cdb_pc_change <= 1'b0;
            cdb_new_pc    <= '0;
          end
          CDB_SRC_BRANCH: begin
            cdb_entry     <= br_data[BASE_W-1:DATA_W];
            cdb_value     <= br_data[DATA_W-1:0];
            cdb_pc_change <= br_data[BR_W-1];
            cdb_new_pc    <= br_data[BR_W-2:BASE_W];
          end
          default: begin
            cdb_entry     <= slb_data[BASE_W-1:DATA_W];
            cdb_value     <= slb_data[DATA_W-1:0];
            cdb_pc_change <= 1'b0;
            cdb_new_pc    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed table-driven bench for cdb_arbiter
module tb_cdb_arbiter;

  typedef struct {
    logic        rst, rdy, clr;
    logic [2:0]  have;          // {slb, branch, rs}
    logic [3:0]  e_rs, e_br, e_slb;
    logic [31:0] v_rs, v_br, v_slb;
    logic        pc;
    logic [31:0] npc;
    logic [2:0]  x_stall;       // {slb, branch, rs}, sampled before the edge
    logic        x_valid;
    logic [3:0]  x_entry;
    logic [31:0] x_value;
    logic [1:0]  x_src;
    logic        x_pc;
    logic [31:0] x_npc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        have_rs, have_branch, have_slb;
  logic [3:0]  entry_rs, entry_branch, entry_slb;
  logic [31:0] value_rs, value_branch, value_slb;
  logic        pc_change_branch;
  logic [31:0] new_pc_branch;
  logic        stall_rs, stall_branch, stall_slb;
  logic        cdb_valid, cdb_pc_change;
  logic [3:0]  cdb_entry;
  logic [31:0] cdb_value, cdb_new_pc;
  logic [1:0]  cdb_src;

  int   errors = 0;
  int   checks = 0;
  int   row_id = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cdb_arbiter #(.TAG_W(4), .DATA_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
    .have_rs(have_rs), .have_branch(have_branch), .have_slb(have_slb),
    .entry_rs(entry_rs), .entry_branch(entry_branch), .entry_slb(entry_slb),
    .value_rs(value_rs), .value_branch(value_branch), .value_slb(value_slb),
    .pc_change_branch(pc_change_branch), .new_pc_branch(new_pc_branch),
    .stall_rs(stall_rs), .stall_branch(stall_branch), .stall_slb(stall_slb),
    .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_value(cdb_value),
    .cdb_src(cdb_src), .cdb_pc_change(cdb_pc_change), .cdb_new_pc(cdb_new_pc)
  );

  function automatic vec_t mk(
    input logic r, input logic y, input logic c, input logic [2:0] h,
    input logic [3:0] ers, input logic [31:0] vrs,
    input logic [3:0] ebr, input logic [31:0] vbr, input logic p, input logic [31:0] np,
    input logic [3:0] esl, input logic [31:0] vsl,
    input logic [2:0] xs, input logic xv, input logic [3:0] xe, input logic [31:0] xval,
    input logic [1:0] xsrc, input logic xp, input logic [31:0] xnp);
    vec_t v;
    v.rst = r; v.rdy = y; v.clr = c; v.have = h;
    v.e_rs = ers; v.v_rs = vrs; v.e_br = ebr; v.v_br = vbr; v.pc = p; v.npc = np;
    v.e_slb = esl; v.v_slb = vsl;
    v.x_stall = xs; v.x_valid = xv; v.x_entry = xe; v.x_value = xval;
    v.x_src = xsrc; v.x_pc = xp; v.x_npc = xnp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; rdy = v.rdy; clr = v.clr;
    have_rs = v.have[0]; have_branch = v.have[1]; have_slb = v.have[2];
    entry_rs = v.e_rs; entry_branch = v.e_br; entry_slb = v.e_slb;
    value_rs = v.v_rs; value_branch = v.v_br; value_slb = v.v_slb;
    pc_change_branch = v.pc; new_pc_branch = v.npc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row_id, act, exp);
    end
  endtask

  task automatic chk_cdb(input logic v, input logic [3:0] e, input logic [31:0] val,
                         input logic [1:0] s, input logic p, input logic [31:0] np);
    chk("cdb_valid", 32'(cdb_valid), 32'(v));
    chk("cdb_entry", 32'(cdb_entry), 32'(e));
    chk("cdb_value", cdb_value, val);
    chk("cdb_src", 32'(cdb_src), 32'(s));
    chk("cdb_pc_change", 32'(cdb_pc_change), 32'(p));
    chk("cdb_new_pc", cdb_new_pc, np);
  endtask

  initial begin
    vec_t idle;
    logic [3:0] rs_t, slb_t, rs_b, slb_b;

    idle = mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 0,0,0,3,0,0);
    apply(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // reset overriding rdy/clear/have, then single rs result
    vecs.push_back(mk(1,0,1,3'b001, 9,'h99, 0,0,0,0, 0,0, 3'b111, 0,0,0,3,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 0,0,0,3,0,0));
    vecs.push_back(mk(0,1,0,3'b001, 5,'h1234, 0,0,0,0, 0,0, 3'b000, 0,0,0,3,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 1,5,'h1234,0,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 0,5,'h1234,3,0,0));
    // clear to reset rr_ptr, then all three at once
    vecs.push_back(mk(0,1,1,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 0,5,'h1234,3,0,0));
    vecs.push_back(mk(0,1,0,3'b111, 1,'h11, 2,'h22,1,'h100, 3,'h33, 3'b000, 0,5,'h1234,3,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b110, 1,1,'h11,0,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b100, 1,2,'h22,1,1,'h100));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 1,3,'h33,2,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 0,3,'h33,3,0,0));
    // flush with rs/branch full and slb presenting
    vecs.push_back(mk(0,1,0,3'b011, 6,'h66, 8,'h88,0,0, 0,0, 3'b000, 0,3,'h33,3,0,0));
    vecs.push_back(mk(0,1,1,3'b100, 0,0, 0,0,0,0, 7,'h77, 3'b010, 0,3,'h33,3,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 0,3,'h33,3,0,0));
    // tag 0 dropped
    vecs.push_back(mk(0,1,0,3'b001, 0,'h99, 0,0,0,0, 0,0, 3'b000, 0,3,'h33,3,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 0,3,'h33,3,0,0));
    // broadcast tag 4, then rdy low with branch waiting
    vecs.push_back(mk(0,1,0,3'b100, 0,0, 0,0,0,0, 4,'h44, 3'b000, 0,3,'h33,3,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 1,4,'h44,2,0,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,0,3'b010, 0,0, 10,'hAA,1,'h200, 0,0, 3'b111, 1,4,'h44,2,0,0));
    vecs.push_back(mk(0,1,0,3'b010, 0,0, 10,'hAA,1,'h200, 0,0, 3'b000, 0,4,'h44,3,0,0));
    vecs.push_back(mk(0,1,0,3'b000, 0,0, 0,0,0,0, 0,0, 3'b000, 1,10,'hAA,1,1,'h200));

    foreach (vecs[i]) begin
      row_id = i;
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk("stall", 32'({stall_slb, stall_branch, stall_rs}), 32'(vecs[i].x_stall));
      @(posedge clk);
      #1;
      chk_cdb(vecs[i].x_valid, vecs[i].x_entry, vecs[i].x_value,
              vecs[i].x_src, vecs[i].x_pc, vecs[i].x_npc);
    end

    // rs and slb continuously busy: grants alternate, no source stalls twice in a row
    row_id = 100;
    @(negedge clk);
    apply(idle);
    clr = 1'b1;
    @(posedge clk);
    rs_t = 4'd1; slb_t = 4'd9; rs_b = 4'd1; slb_b = 4'd9;
    for (int c = 0; c <= 8; c++) begin
      row_id = 100 + c;
      @(negedge clk);
      apply(idle);
      have_rs = 1'b1; entry_rs = rs_t; value_rs = 32'h100 + 32'(rs_t);
      have_slb = 1'b1; entry_slb = slb_t; value_slb = 32'h200 + 32'(slb_t);
      #1;
      if (c == 0) begin
        chk("rr_stall", 32'({stall_slb, stall_rs}), 32'b00);
        rs_t++; slb_t++;
      end else if (c % 2 == 1) begin
        chk("rr_stall", 32'({stall_slb, stall_rs}), 32'b10);
        rs_t++;
      end else begin
        chk("rr_stall", 32'({stall_slb, stall_rs}), 32'b01);
        slb_t++;
      end
      @(posedge clk);
      #1;
      if (c == 0) begin
        chk("rr_valid", 32'(cdb_valid), 32'd0);
      end else if (c % 2 == 1) begin
        chk_cdb(1'b1, rs_b, 32'h100 + 32'(rs_b), 2'd0, 1'b0, 32'd0);
        rs_b++;
      end else begin
        chk_cdb(1'b1, slb_b, 32'h200 + 32'(slb_b), 2'd2, 1'b0, 32'd0);
        slb_b++;
      end
    end

    @(negedge clk);
    apply(idle);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
